// File: rtl/hex_word_serializer_pkg.sv
// Shared types and constants for the hex word serializer.
// The CR/LF states only exist when HEX_SER_EOL_EN is defined; otherwise the state is a single bit.
package hex_ser_pkg;

`ifdef HEX_SER_EOL_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIGIT = 2'd1,
    CR    = 2'd2,
    LF    = 2'd3
  } state_e;
`else
  typedef enum logic {
    IDLE  = 1'b0,
    DIGIT = 1'b1
  } state_e;
`endif

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A_LO = 8'h61;
  localparam logic [7:0] ASCII_A_UP = 8'h41;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  // A single-nibble word still needs a one-bit counter.
  function automatic int cnt_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/hex_word_serializer_nibble.sv
// Combinational 4-bit value to ASCII hex digit; UPPER selects 'A'..'F' over 'a'..'f'.
// Zero latency, no handshake.
module nibble_to_ascii
  import hex_ser_pkg::*;
#(
  parameter int UPPER = 0
) (
  input  logic [3:0] nib_i,
  output logic [7:0] char_o
);

  always_comb begin
    if (nib_i < 4'd10) begin
      char_o = ASCII_ZERO + {4'd0, nib_i};
    end else if (UPPER != 0) begin
      char_o = ASCII_A_UP + {4'd0, nib_i} - 8'd10;
    end else begin
      char_o = ASCII_A_LO + {4'd0, nib_i} - 8'd10;
    end
  end

endmodule

// File: rtl/hex_word_serializer.sv
// Word in, ASCII hex characters out MSB nibble first; first character one cycle after acceptance.
// Characters hold while char_ready is low; din_ready is high when idle or on the final character. Optional CR/LF: HEX_SER_EOL_EN.
module hex_word_serializer
  import hex_ser_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int UPPER = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [7:0]       char_out,
  output logic             char_valid,
  input  logic             char_ready,
  output logic             busy
);

  localparam int NIB   = WIDTH / 4;
  localparam int CNT_W = cnt_width(NIB);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       char_q, char_d;
  logic             vld_q;
  logic             busy_q;
  logic [7:0]       nib_char;
  logic             word_done;
  logic             load;

  // The last character of a word is leaving this cycle.
  always_comb begin
    word_done = 1'b0;
`ifdef HEX_SER_EOL_EN
    if (state_q == LF) word_done = char_ready;
`else
    if (state_q == DIGIT && cnt_q == '0) word_done = char_ready;
`endif
  end

  assign din_ready = (state_q == IDLE) || word_done;
  assign load      = din_valid && din_ready;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load) begin
      state_d = DIGIT;
      shift_d = din;
      cnt_d   = CNT_LAST;
    end else if (word_done) begin
      state_d = IDLE;
      shift_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        DIGIT: begin
          if (char_ready) begin
            shift_d = shift_q << 4;
`ifdef HEX_SER_EOL_EN
            if (cnt_q == '0) state_d = CR;
            else cnt_d = cnt_q - CNT_ONE;
`else
            cnt_d = cnt_q - CNT_ONE;
`endif
          end
        end
`ifdef HEX_SER_EOL_EN
        CR: begin
          if (char_ready) state_d = LF;
        end
`endif
        default: ;
      endcase
    end
  end

  // Convert the upcoming top nibble so char_out can be a plain register.
  nibble_to_ascii #(
    .UPPER(UPPER)
  ) u_nib (
    .nib_i (shift_d[WIDTH-1 -: 4]),
    .char_o(nib_char)
  );

  always_comb begin
    char_d = 8'h00;
    case (state_d)
      DIGIT:   char_d = nib_char;
`ifdef HEX_SER_EOL_EN
      CR:      char_d = ASCII_CR;
      LF:      char_d = ASCII_LF;
`endif
      default: char_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      char_q  <= 8'h00;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      char_q  <= char_d;
      vld_q   <= (state_d != IDLE);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign char_out   = char_q;
  assign char_valid = vld_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_hex_word_serializer.sv
// Bench for hex_word_serializer: a WIDTH=16 lowercase instance and a WIDTH=4 uppercase instance,
// each checked every cycle against a character-queue model plus literal character logs.
module tb_hex_word_serializer;

  typedef struct packed {
    logic [7:0] c;
    logic       last;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din [2];
  logic        dv [2];
  logic        dr [2];
  logic [7:0]  co [2];
  logic        cv [2];
  logic        cr [2];
  logic        bz [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] log_c0[$], log_c1[$], exp_log[$];
  int         log_t0[$], log_t1[$], acc_t0[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  hex_word_serializer #(.WIDTH(16), .UPPER(0)) u16 (
    .clk(clk), .rst_n(rst_n), .din(din[0]), .din_valid(dv[0]), .din_ready(dr[0]),
    .char_out(co[0]), .char_valid(cv[0]), .char_ready(cr[0]), .busy(bz[0])
  );

  hex_word_serializer #(.WIDTH(4), .UPPER(1)) u4 (
    .clk(clk), .rst_n(rst_n), .din(din[1][3:0]), .din_valid(dv[1]), .din_ready(dr[1]),
    .char_out(co[1]), .char_valid(cv[1]), .char_ready(cr[1]), .busy(bz[1])
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] hexc(input int n, input int up);
    if (n < 10) return 8'(48 + n);
    return 8'(((up != 0) ? 65 : 97) + n - 10);
  endfunction

  // Model: queue of characters still owed by accepted words.
  for (genvar g = 0; g < 2; g++) begin : g_chk
    localparam int W  = (g == 0) ? 16 : 4;
    localparam int UP = (g == 0) ? 0 : 1;
    ent_t       q[$];
    ent_t       e;
    logic       ev, er, pv, pr;
    logic [7:0] ec, pc;

    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
        pv = 1'b0;
        check($sformatf("u%0d.rst_valid", g), cv[g], 0);
        check($sformatf("u%0d.rst_char", g), co[g], 0);
        check($sformatf("u%0d.rst_ready", g), dr[g], 1);
        check($sformatf("u%0d.rst_busy", g), bz[g], 0);
      end else begin
        ev = (q.size() > 0);
        ec = ev ? q[0].c : 8'h00;
        er = !ev || (cr[g] && q[0].last);
        check($sformatf("u%0d.char_valid", g), cv[g], ev);
        check($sformatf("u%0d.char_out", g), co[g], ec);
        check($sformatf("u%0d.busy", g), bz[g], ev);
        check($sformatf("u%0d.din_ready", g), dr[g], er);
        if (pv && !pr) check($sformatf("u%0d.stall_hold", g), co[g], pc);
        pv = cv[g];
        pr = cr[g];
        pc = co[g];
        if (ev && cr[g]) begin
          if (g == 0) begin log_c0.push_back(co[g]); log_t0.push_back(cyc); end
          else        begin log_c1.push_back(co[g]); log_t1.push_back(cyc); end
          void'(q.pop_front());
        end
        if (dv[g] && er) begin
          if (g == 0) acc_t0.push_back(cyc);
          for (int k = W / 4 - 1; k >= 0; k--) begin
            e.c    = hexc(int'((din[g] >> (4 * k)) & 16'hF), UP);
`ifdef HEX_SER_EOL_EN
            e.last = 1'b0;
`else
            e.last = (k == 0);
`endif
            q.push_back(e);
          end
`ifdef HEX_SER_EOL_EN
          e.c = 8'h0D; e.last = 1'b0; q.push_back(e);
          e.c = 8'h0A; e.last = 1'b1; q.push_back(e);
`endif
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a word and return just after the edge that accepted it, valid left high.
  task automatic put(input int g, input logic [15:0] w);
    bit ok;
    ok = 1'b0;
    din[g] = w;
    dv[g]  = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = dr[g];
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL put_timeout: u%0d word %0h never accepted", g, w);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log_c0.delete(); log_c1.delete(); log_t0.delete(); log_t1.delete(); acc_t0.delete();
  endtask

  task automatic check_log(input int g, input string nm, input bit contig);
    int n, gaps;
    n    = (g == 0) ? log_c0.size() : log_c1.size();
    gaps = 0;
    check({nm, ".count"}, n, exp_log.size());
    for (int i = 0; i < n && i < exp_log.size(); i++)
      check($sformatf("%s[%0d]", nm, i), (g == 0) ? log_c0[i] : log_c1[i], exp_log[i]);
    if (contig) begin
      for (int i = 1; i < n; i++)
        if (((g == 0) ? (log_t0[i] - log_t0[i-1]) : (log_t1[i] - log_t1[i-1])) != 1) gaps++;
      check({nm, ".bubbles"}, gaps, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int g = 0; g < 2; g++) begin
      din[g] = '0; dv[g] = 1'b0; cr[g] = 1'b1;
    end
    #3;
    check("reset.valid", cv[0], 0);
    check("reset.char", co[0], 8'h00);
    check("reset.ready", dr[0], 1);
    check("reset.busy", bz[0], 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // Basic word; din changes after acceptance must not matter.
    clear_logs();
    put(0, 16'hBEEF);
    dv[0] = 1'b0; din[0] = 16'hFFFF;
    idle(8);
    exp_log = '{8'h62, 8'h65, 8'h65, 8'h66};
    check_log(0, "beef", 1'b1);
    if (log_t0.size() > 0 && acc_t0.size() > 0) check("beef.latency", log_t0[0] - acc_t0[0], 1);
    else check("beef.latency_missing", log_t0.size(), 4);

    // Back-to-back words, no bubble.
    clear_logs();
    put(0, 16'h0009);
    put(0, 16'h00A0);
    dv[0] = 1'b0;
    idle(12);
    exp_log = '{8'h30, 8'h30, 8'h30, 8'h39, 8'h30, 8'h30, 8'h61, 8'h30};
    check_log(0, "b2b", 1'b1);

    // Downstream stalls.
    clear_logs();
    put(0, 16'h1234);
    dv[0] = 1'b0;
    foreach (exp_log[i]) exp_log.delete(i);
    for (int i = 0; i < 7; i++) begin
      cr[0] = (7'b1101001 >> i) & 7'd1;
      idle(1);
    end
    cr[0] = 1'b1;
    idle(4);
    exp_log = '{8'h31, 8'h32, 8'h33, 8'h34};
    check_log(0, "stall", 1'b0);

    // Reset mid-word discards the rest.
    clear_logs();
    put(0, 16'hCAFE);
    dv[0] = 1'b0;
    idle(2);
    rst_n = 1'b0;
    #1;
    check("midrst.valid", cv[0], 0);
    check("midrst.char", co[0], 8'h00);
    check("midrst.ready", dr[0], 1);
    check("midrst.busy", bz[0], 0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    put(0, 16'h0001);
    dv[0] = 1'b0;
    idle(8);
    exp_log = '{8'h63, 8'h61, 8'h30, 8'h30, 8'h30, 8'h31};
    check_log(0, "midrst", 1'b0);

    // Single-nibble words, uppercase, all values back-to-back.
    clear_logs();
    for (int i = 0; i < 16; i++) put(1, 16'(i));
    dv[1] = 1'b0;
    idle(4);
    exp_log = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    check_log(1, "sweep4", 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
